cva6_fifo_out_stage: RTL
========================

# cva6_fifo_out_stage

Registered output stage placed directly downstream of a CVA6 FIFO. It drains the FIFO through its `empty`/`pop` interface and presents the data as a valid/ready stream to the consumer. A 2-entry buffer (head plus skid) lets the FIFO pop decision depend only on local registered state and `fifo_empty_i`, never on the consumer's `ready_i`. This cuts the combinational path between consumer back-pressure and FIFO pointers while keeping full throughput.

## Interface
- `DATA_WIDTH`, default 32: payload width when `dtype` is not overridden.
- `dtype`, default `logic [DATA_WIDTH-1:0]`: payload type.
- `STALL_CNT_WIDTH`, default 16: width of the stall performance counter.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `flush_i`  in  1  synchronous flush; the same flush is applied to the upstream FIFO.
- `fifo_empty_i`  in  1  upstream FIFO `empty_o`.
- `fifo_data_i`  in  dtype  upstream FIFO `data_o` (head of queue).
- `fifo_pop_o`  out  1  upstream FIFO `pop_i`.
- `valid_o`  out  1  `data_o` is valid.
- `data_o`  out  dtype  head entry.
- `ready_i`  in  1  consumer accepts `data_o` this cycle.
- `occupancy_o`  out  2  entries held (0..2).
- `stall_cnt_o`  out  STALL_CNT_WIDTH  cycles with `valid_o & ~ready_i`; saturating.

## Operation
- State:
  - head register A
  - skid register B
  - `cnt_q` in {0,1,2}
  - stall counter
- `valid_o = (cnt_q != 0)`.
- `data_o` = A.
- `occupancy_o = cnt_q`.
- `fifo_pop_o = ~fifo_empty_i & ~flush_i & ~rst_i & (cnt_q != 2)`. It must not depend on `ready_i`.
- `fire = valid_o & ready_i`. `pop = fifo_pop_o`.
- Transitions:
  - cnt 0, pop: A ← `fifo_data_i`, cnt → 1.
  - cnt 0, no pop: hold.
  - cnt 1, fire & pop: A ← `fifo_data_i`, cnt stays 1.
  - cnt 1, fire only: cnt → 0; A retains its value.
  - cnt 1, pop only: B ← `fifo_data_i`, cnt → 2.
  - cnt 1, neither: hold.
  - cnt 2, fire: A ← B, cnt → 1. Pop is impossible in this state.
  - cnt 2, no fire: hold; A and B stable.
- Ordering: strict FIFO order is preserved; B is never output before A.
- Flush has priority over all other events:
  - next cycle `cnt_q` = 0 and `valid_o` = 0.
  - A and B keep their stale values.
  - No pop is issued during the flush cycle.
  - A handshake on `valid_o & ready_i` during the flush cycle still counts as consumed by the consumer.
- Stall counter:
  - increments by 1 each cycle `valid_o & ~ready_i`.
  - saturates at all-ones.
  - unaffected by flush; cleared only by reset.
- `data_o` while `valid_o` = 0 is the last value held in A. Consumers must ignore it.

## Timing
- Reset values, asserted asynchronously:
  - `cnt_q` = 0, A = 0, B = 0, stall counter = 0.
  - Therefore `valid_o` = 0, `data_o` = 0, `occupancy_o` = 0, `stall_cnt_o` = 0.
  - `fifo_pop_o` = 0 while `rst_i` is high.
- Latency: FIFO head popped in cycle N appears on `data_o` with `valid_o` = 1 in cycle N+1.
- Throughput: 1 beat/cycle sustained when the FIFO is non-empty and `ready_i` is held high; steady state is cnt = 1.
- Back-pressure: after `ready_i` drops, at most one further pop occurs (filling B), then `fifo_pop_o` = 0 until a fire.
- The upstream FIFO is used with `FALL_THROUGH` = 0 or 1. Either way `fifo_data_i` is sampled only in a cycle where `fifo_pop_o` = 1.
- Reset released mid-stream: the first pop occurs in the first cycle with `rst_i` = 0 and `fifo_empty_i` = 0.
- `fifo_pop_o` is never asserted while `fifo_empty_i` = 1. The bench checks this with an assertion.

## Test plan
- **Reset:** hold `rst_i` = 1 with `fifo_empty_i` = 0 and `ready_i` = 1 → `fifo_pop_o` = 0, `valid_o` = 0, `data_o` = 0, `stall_cnt_o` = 0. Release reset with FIFO head 0x11 → `fifo_pop_o` = 1 that cycle, and `data_o` = 0x11 with `valid_o` = 1 the next cycle.
- **Streaming:** FIFO holds 0x1..0x8 and `ready_i` = 1 → eight consecutive fires output 0x1..0x8 in order, one per cycle starting 1 cycle after the first pop; `occupancy_o` = 1 throughout the burst.
- **Back-pressure:** stream 0xA0, 0xA1, 0xA2 and drop `ready_i` after the fire of 0xA0.
  - Required: exactly one more pop; `occupancy_o` = 2; `fifo_pop_o` = 0 while stalled.
  - Hold 5 cycles: `stall_cnt_o` increments by 5.
  - Raise `ready_i`: 0xA1 then 0xA2 are output with no gap, and no beat is lost or duplicated.
- **Flush:** with `occupancy_o` = 2, assert `flush_i` for 1 cycle while the FIFO is non-empty → `fifo_pop_o` = 0 in the flush cycle; `valid_o` = 0 and `occupancy_o` = 0 next cycle; `stall_cnt_o` unchanged.
- **Saturation:** set `STALL_CNT_WIDTH` = 4 and stall for 20 cycles → `stall_cnt_o` = 0xF and holds.
- **Random:** random `fifo_empty_i`/`ready_i` over 10k cycles against a scoreboard → output order equals pop order, with no pop while empty.

Source files
------------

// File: rtl/cva6_fifo_out_stage.sv
// cva6_fifo_out_stage: two-entry registered output stage that drains a FIFO into a valid/ready stream
module cva6_fifo_out_stage #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter type         dtype           = logic [DATA_WIDTH-1:0],
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       fifo_empty_i,
    input  dtype                       fifo_data_i,
    output logic                       fifo_pop_o,
    output logic                       valid_o,
    output dtype                       data_o,
    input  logic                       ready_i,
    output logic [1:0]                 occupancy_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);
    dtype                       head_q, skid_q;
    logic [1:0]                 cnt_q;
    logic [STALL_CNT_WIDTH-1:0] stall_q;
    logic                       fire;

    assign valid_o     = cnt_q != 2'd0;
    assign data_o      = head_q;
    assign occupancy_o = cnt_q;
    assign stall_cnt_o = stall_q;
    assign fire        = valid_o & ready_i;
    assign fifo_pop_o  = ~fifo_empty_i & ~flush_i & ~rst_i & (cnt_q != 2'd2);

    // head/skid buffer: pop decision uses only local state, skid absorbs the beat popped while stalled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            cnt_q <= 2'd0;
        end else if (cnt_q == 2'd0) begin
            if (fifo_pop_o) begin
                head_q <= fifo_data_i;
                cnt_q  <= 2'd1;
            end
        end else if (cnt_q == 2'd1) begin
            if (fire && fifo_pop_o) begin
                head_q <= fifo_data_i;
            end else if (fire) begin
                cnt_q <= 2'd0;
            end else if (fifo_pop_o) begin
                skid_q <= fifo_data_i;
                cnt_q  <= 2'd2;
            end
        end else if (fire) begin
            head_q <= skid_q;
            cnt_q  <= 2'd1;
        end
    end

    // saturating count of cycles where the consumer holds off valid data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_q <= '0;
        else if (valid_o && !ready_i && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end
endmodule
